// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode pixel pipeline.
package text_pkg;

    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 8;
    localparam int FONT_AD_W = 11;
    localparam int TEXT_AD_W = 13;
    localparam int PIPE_LAT  = 4;

    typedef logic [2:0] rgb_t;

endpackage

// File: rtl/text_renderer_pipe_delay.sv
// N-stage, W-bit shift register with a synchronous reset value; one shared carry line per signal.
module pipe_delay #(
    parameter int           N       = 4,
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [N];

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel generator: cell address -> text RAM -> font ROM -> serialised pixel,
// with a blinking cursor and sync/blank delayed to stay aligned with rgb.
module text_renderer
    import text_pkg::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 60,
    parameter logic [2:0] FG         = 3'b111,
    parameter logic [2:0] BG         = 3'b000,
    parameter logic       SYNC_IDLE  = 1'b1,
    parameter int         BLINK_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic                 de,
    input  logic                 hsync,
    input  logic                 vsync,
    output logic [TEXT_AD_W-1:0] text_ad,
    input  logic [7:0]           char_code,
    output logic [FONT_AD_W-1:0] font_ad,
    input  logic [7:0]           font_dout,
    input  logic                 cursor_en,
    input  logic [6:0]           cursor_col,
    input  logic [5:0]           cursor_row,
    output logic [2:0]           rgb,
    output logic                 de_o,
    output logic                 hsync_o,
    output logic                 vsync_o
);

    if (COLS * ROWS > (1 << TEXT_AD_W)) begin : g_bad_geometry
        $error("text_renderer: COLS*ROWS does not fit the text RAM address");
    end

    // Frame counter: counts vsync rising edges, MSB drives the cursor blink.
    logic                  vsync_q;
    logic [BLINK_LOG2:0]   frame_q, frame_d;
    logic                  blink;

    always_comb begin
        frame_d = frame_q;
        if (vsync && !vsync_q) frame_d = frame_q + {{BLINK_LOG2{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q <= SYNC_IDLE;
            frame_q <= '0;
        end else begin
            vsync_q <= vsync;
            frame_q <= frame_d;
        end
    end

    assign blink = frame_q[BLINK_LOG2];

    // Stage 1: cell address; cursor and blink are sampled here so both apply to this pixel.
    logic [TEXT_AD_W-1:0] cell_row, cell_col, text_ad_d, text_ad_q;
    logic                 hit_d;

    always_comb begin
        cell_row  = TEXT_AD_W'(y[9:3]);
        cell_col  = TEXT_AD_W'(x[9:3]);
        text_ad_d = de ? (cell_row * TEXT_AD_W'(COLS) + cell_col) : '0;
        hit_d     = cursor_en && blink && (x[9:3] == cursor_col) && (y[9:3] == {1'b0, cursor_row});
    end

    always_ff @(posedge clk) begin
        if (reset) text_ad_q <= '0;
        else       text_ad_q <= text_ad_d;
    end

    assign text_ad = text_ad_q;

    // Carries that keep the glyph coordinates, cursor and timing aligned with the memory reads.
    logic [2:0] col_d3, row_d2;
    logic       de_d3, hit_d3;

    pipe_delay #(.N(3), .W(3), .RST_VAL(3'b000)) u_col_pipe (
        .clk(clk), .reset(reset), .d_i(x[2:0]), .q_o(col_d3)
    );

    pipe_delay #(.N(2), .W(3), .RST_VAL(3'b000)) u_row_pipe (
        .clk(clk), .reset(reset), .d_i(y[2:0]), .q_o(row_d2)
    );

    pipe_delay #(.N(3), .W(1), .RST_VAL(1'b0)) u_de_pipe (
        .clk(clk), .reset(reset), .d_i(de), .q_o(de_d3)
    );

    pipe_delay #(.N(3), .W(1), .RST_VAL(1'b0)) u_hit_pipe (
        .clk(clk), .reset(reset), .d_i(hit_d), .q_o(hit_d3)
    );

    pipe_delay #(.N(PIPE_LAT), .W(1), .RST_VAL(SYNC_IDLE)) u_hsync_pipe (
        .clk(clk), .reset(reset), .d_i(hsync), .q_o(hsync_o)
    );

    pipe_delay #(.N(PIPE_LAT), .W(1), .RST_VAL(SYNC_IDLE)) u_vsync_pipe (
        .clk(clk), .reset(reset), .d_i(vsync), .q_o(vsync_o)
    );

    // Stage 2: glyph row address straight from the RAM data.
    assign font_ad = {char_code, row_d2};

    // Stages 3-4: pick the glyph bit (MSB is leftmost) and register the pixel.
    logic glyph_bit;
    rgb_t rgb_d, rgb_q;
    logic de_q;

    always_comb begin
        glyph_bit = font_dout[3'(CHAR_W - 1) - col_d3];
        rgb_d     = '0;
        if (de_d3) rgb_d = (glyph_bit ^ hit_d3) ? FG : BG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= de_d3;
        end
    end

    assign rgb  = rgb_q;
    assign de_o = de_q;

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer: behavioural text RAM / font ROM, a pixel-level
// reference model, hand-written vector tables and randomized stimulus.
module tb_text_renderer;

    localparam int         COLS = 80;
    localparam logic [2:0] FG   = 3'b111;
    localparam logic [2:0] BG   = 3'b000;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        de, hsync, vsync;
    logic [12:0] text_ad;
    logic [7:0]  char_code, font_dout;
    logic [10:0] font_ad;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [2:0]  rgb;
    logic        de_o, hsync_o, vsync_o;

    text_renderer dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
        .text_ad(text_ad), .char_code(char_code), .font_ad(font_ad), .font_dout(font_dout),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .rgb(rgb), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories around the DUT; force_en overrides the ROM data.
    logic [7:0] ram [8192];
    logic [7:0] rom [2048];
    logic       force_en;
    logic [7:0] force_val;

    always @(posedge clk) begin
        char_code <= ram[text_ad];
        font_dout <= force_en ? force_val : rom[font_ad];
    end

    typedef struct {
        logic [2:0] rgb;
        logic       de;
        logic       hs;
        logic       vs;
    } out_t;

    typedef struct {
        int x;
        int y;
        int exp_ad;
    } ad_vec_t;

    out_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         frames;
    logic       prev_vs;
    logic [10:0] exp_font_ad;
    bit         font_ad_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One pixel clock: drive inputs, predict the pixel it produces 4 clocks later, compare.
    task automatic step(input bit rst, input int xi, input int yi, input bit dei,
                        input bit hsi, input bit vsi, input int hand_rgb);
        out_t       e, got_e;
        int         cc, cr, addr, exp_ad;
        logic [7:0] glyph;
        bit         gbit, curs;
        reset = rst; x = 10'(xi); y = 10'(yi); de = dei; hsync = hsi; vsync = vsi;
        cc = xi / 8; cr = yi / 8; addr = cr * COLS + cc;
        exp_ad = (rst || !dei) ? 0 : addr;
        if (rst) begin
            exp_q.delete();
            repeat (4) exp_q.push_back('{rgb: 3'b000, de: 1'b0, hs: 1'b1, vs: 1'b1});
            frames  = 0;
            prev_vs = 1'b1;
        end else begin
            glyph = force_en ? force_val : rom[int'(ram[addr]) * 8 + yi % 8];
            gbit  = glyph[7 - xi % 8];
            curs  = cursor_en && cc == int'(cursor_col) && cr == int'(cursor_row) && ((frames / 16) % 2 == 1);
            e.rgb = !dei ? 3'b000 : ((gbit ^ curs) ? FG : BG);
            if (hand_rgb >= 0) e.rgb = 3'(hand_rgb);
            e.de = dei; e.hs = hsi; e.vs = vsi;
            exp_q.push_back(e);
            if (vsi && !prev_vs) frames++;
            prev_vs = vsi;
        end
        @(posedge clk);
        #1;
        got_e = exp_q.pop_front();
        check("rgb", 32'(rgb), 32'(got_e.rgb));
        check("de_o", 32'(de_o), 32'(got_e.de));
        check("hsync_o", 32'(hsync_o), 32'(got_e.hs));
        check("vsync_o", 32'(vsync_o), 32'(got_e.vs));
        check("text_ad", 32'(text_ad), 32'(exp_ad));
        if (font_ad_valid && !rst) check("font_ad", 32'(font_ad), 32'(exp_font_ad));
        exp_font_ad   = {ram[exp_ad], 3'(yi % 8)};
        font_ad_valid = !rst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 1, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ad_vec_t    ad_tbl[5];
        int         bit_tbl[8];

        ad_tbl[0] = '{x: 17,  y: 9,   exp_ad: 82};
        ad_tbl[1] = '{x: 0,   y: 0,   exp_ad: 0};
        ad_tbl[2] = '{x: 8,   y: 8,   exp_ad: 81};
        ad_tbl[3] = '{x: 639, y: 479, exp_ad: 4799};
        ad_tbl[4] = '{x: 320, y: 100, exp_ad: 1000};
        bit_tbl   = '{int'(FG), int'(BG), int'(BG), int'(BG), int'(BG), int'(BG), int'(BG), int'(FG)};

        for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        ram[82]   = 8'h41;
        force_en  = 1'b0;
        force_val = 8'h00;
        cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 6'd0;

        // Reset held 3 cycles with random inputs, then 4 blank cycles after release.
        for (int i = 0; i < 3; i++)
            step(1, $urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom), 1'($urandom), 1'($urandom), -1);
        idle(4);

        // Address generation from a constant table.
        foreach (ad_tbl[i]) begin
            step(0, ad_tbl[i].x, ad_tbl[i].y, 1, 1, 1, -1);
            check("tbl_text_ad", 32'(text_ad), 32'(ad_tbl[i].exp_ad));
        end
        step(0, 17, 9, 1, 1, 1, -1);
        step(0, 0, 0, 0, 1, 1, -1);
        check("font_ad_0x41", 32'(font_ad), 32'h209);
        idle(4);

        // Bit order: glyph 0x81 across one cell.
        force_en = 1'b1; force_val = 8'h81;
        idle(4);
        for (int i = 0; i < 8; i++) step(0, 40 + i, 24, 1, 1, 1, bit_tbl[i]);
        idle(4);
        force_en = 1'b0;

        // Blanking and sync alignment with distinct de/hsync/vsync patterns.
        for (int i = 0; i < 40; i++)
            step(0, i * 8 + 3, 200 + i, (i % 3) != 0, (i % 5) < 2, (i % 7) < 3, -1);
        idle(4);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                cursor_en  = 1'($urandom);
                cursor_col = 7'($urandom_range(0, 4));
                cursor_row = 6'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 1) == 0)
                step(0, $urandom_range(0, 39), $urandom_range(0, 23), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 5) != 0, -1);
            else
                step(0, $urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 5) != 0, -1);
        end
        idle(4);

        // Cursor blink at cell (2,1): BG for frames 0-15, FG after 16 vsync rising edges.
        step(1, 0, 0, 0, 1, 1, -1);
        idle(4);
        cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 6'd1;
        force_en = 1'b1; force_val = 8'h00;
        idle(4);
        for (int f = 0; f <= 16; f++) begin
            for (int px = 8; px < 32; px++)
                step(0, px, 8 + (f % 8), 1, 1, 1, (px / 8 == 2 && f >= 16) ? int'(FG) : int'(BG));
            idle(2);
            step(0, 0, 0, 0, 1, 0, -1);
            step(0, 0, 0, 0, 1, 0, -1);
            idle(2);
        end
        idle(4);
        force_en = 1'b0; cursor_en = 1'b0;

        // Reset for one cycle in the middle of an active line.
        for (int px = 0; px < 64; px++)
            step(px == 30, px, 16, 1, px > 50, 1, -1);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
